// File: rtl/rv32i_inst_encoder.sv
// ============================================================================
// rv32i_inst_encoder : encodes RV32I requests into words and streams them into imem
// Rev 1.0
// ============================================================================
`default_nettype none

module rv32i_inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [3:0]               req_class_i,
  input  logic [4:0]               req_alu_i,
  input  logic [2:0]               req_f3_i,
  input  logic [4:0]               req_rd_i,
  input  logic [4:0]               req_rs1_i,
  input  logic [4:0]               req_rs2_i,
  input  logic [31:0]              req_imm_i,
  output logic                     imem_we_o,
  input  logic                     imem_ready_i,
  output logic [ADDR_W-1:0]        imem_addr_o,
  output logic [31:0]              imem_wdata_o,
  output logic                     err_o,
  output logic [7:0]               err_count_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;

  logic        alu_ok, alu_shift, alu_sub;
  logic [6:0]  alu_f7;
  logic [2:0]  alu_f3;
  logic        imm12_ok, bimm_ok, jimm_ok, shamt_ok;
  logic        legal;
  logic [31:0] word;
  logic        full, accept, push, pop;

  // ALUcontrol code -> (funct7, funct3)
  always_comb begin
    alu_ok    = 1'b1;
    alu_shift = 1'b0;
    alu_sub   = 1'b0;
    alu_f7    = 7'h00;
    alu_f3    = 3'd0;
    case (req_alu_i)
      5'b00000: alu_f3 = 3'd0;
      5'b10000: begin alu_f7 = 7'h20; alu_sub = 1'b1; end
      5'b00100: begin alu_f3 = 3'd1; alu_shift = 1'b1; end
      5'b10111: alu_f3 = 3'd2;
      5'b11000: alu_f3 = 3'd3;
      5'b00011: alu_f3 = 3'd4;
      5'b00101: begin alu_f3 = 3'd5; alu_shift = 1'b1; end
      5'b00110: begin alu_f7 = 7'h20; alu_f3 = 3'd5; alu_shift = 1'b1; end
      5'b00010: alu_f3 = 3'd6;
      5'b00001: alu_f3 = 3'd7;
      default:  alu_ok = 1'b0;
    endcase
  end

  // Range checks reduce to "upper bits are a pure sign extension"
  assign imm12_ok = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
  assign bimm_ok  = ((&req_imm_i[31:12]) | ~(|req_imm_i[31:12])) & ~req_imm_i[0];
  assign jimm_ok  = ((&req_imm_i[31:20]) | ~(|req_imm_i[31:20])) & ~req_imm_i[0];
  assign shamt_ok = ~(|req_imm_i[31:5]);

  always_comb begin
    legal = 1'b0;
    word  = 32'h0;
    case (req_class_i)
      4'd0: begin
        legal = alu_ok;
        word  = {alu_f7, req_rs2_i, req_rs1_i, alu_f3, req_rd_i, OP_R};
      end
      4'd1: begin
        if (alu_shift) begin
          legal = alu_ok & shamt_ok;
          word  = {alu_f7, req_imm_i[4:0], req_rs1_i, alu_f3, req_rd_i, OP_IMM};
        end else begin
          legal = alu_ok & ~alu_sub & imm12_ok;
          word  = {req_imm_i[11:0], req_rs1_i, alu_f3, req_rd_i, OP_IMM};
        end
      end
      4'd2: begin
        legal = imm12_ok & (req_f3_i != 3'd3) & (req_f3_i < 3'd6);
        word  = {req_imm_i[11:0], req_rs1_i, req_f3_i, req_rd_i, OP_LOAD};
      end
      4'd3: begin
        legal = imm12_ok;
        word  = {req_imm_i[11:0], req_rs1_i, 3'b000, req_rd_i, OP_JALR};
      end
      4'd4: begin
        legal = imm12_ok & (req_f3_i <= 3'd2);
        word  = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_f3_i, req_imm_i[4:0], OP_STORE};
      end
      4'd5: begin
        legal = bimm_ok & (req_f3_i != 3'd2) & (req_f3_i != 3'd3);
        word  = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_f3_i,
                 req_imm_i[4:1], req_imm_i[11], OP_BRANCH};
      end
      4'd6: begin
        legal = 1'b1;
        word  = {req_imm_i[31:12], req_rd_i, OP_LUI};
      end
      4'd7: begin
        legal = 1'b1;
        word  = {req_imm_i[31:12], req_rd_i, OP_AUIPC};
      end
      4'd8: begin
        legal = jimm_ok;
        word  = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                 req_rd_i, OP_JAL};
      end
      default: legal = 1'b0;
    endcase
  end

  // Full blocks acceptance even when a pop frees a slot on the same edge
  assign full   = (count_q == LVL_W'(DEPTH));
  assign accept = req_valid_i & ~full & ~flush_i;
  assign push   = accept & legal;
  assign pop    = (count_q != '0) & imem_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_d       = accept & ~legal;
    err_count_d = err_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      addr_d   = addr_q + ADDR_W'(4);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = ADDR_W'(BASE_ADDR);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign req_ready_o  = ~full;
  assign imem_we_o    = (count_q != '0);
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = mem_q[rd_ptr_q];
  assign err_o        = err_q;
  assign err_count_o  = err_count_q;
  assign fifo_level_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_inst_encoder.sv
// ============================================================================
// tb_rv32i_inst_encoder : directed self-checking bench for rv32i_inst_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_inst_encoder;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, imem_ready;
  logic [3:0]  req_class;
  logic [4:0]  req_alu, req_rd, req_rs1, req_rs2;
  logic [2:0]  req_f3;
  logic [31:0] req_imm;

  logic        ready_a, we_a, err_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic [7:0]  errc_a;
  logic [2:0]  lvl_a;

  logic        ready_b, we_b, err_b;
  logic [3:0]  addr_b;
  logic [31:0] wdata_b;
  logic [7:0]  errc_b;
  logic [2:0]  lvl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_inst_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(ready_a), .req_class_i(req_class), .req_alu_i(req_alu),
    .req_f3_i(req_f3), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .req_imm_i(req_imm), .imem_we_o(we_a), .imem_ready_i(imem_ready),
    .imem_addr_o(addr_a), .imem_wdata_o(wdata_a), .err_o(err_a),
    .err_count_o(errc_a), .fifo_level_o(lvl_a)
  );

  rv32i_inst_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(ready_b), .req_class_i(req_class), .req_alu_i(req_alu),
    .req_f3_i(req_f3), .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .req_imm_i(req_imm), .imem_we_o(we_b), .imem_ready_i(imem_ready),
    .imem_addr_o(addr_b), .imem_wdata_o(wdata_b), .err_o(err_b),
    .err_count_o(errc_b), .fifo_level_o(lvl_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] cls, input logic [4:0] alu, input logic [2:0] f3,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm);
    req_valid = 1'b1;
    req_class = cls;
    req_alu   = alu;
    req_f3    = f3;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; imem_ready = 1'b0;
    req_class = 4'd0; req_alu = 5'd0; req_f3 = 3'd0;
    req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
    #3;
    chk("rst_we", {31'd0, we_a}, 32'd0);
    chk("rst_addr", {22'd0, addr_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_errc", {24'd0, errc_a}, 32'd0);
    chk("rst_lvl", {29'd0, lvl_a}, 32'd0);
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    step(); step();
    reset = 1'b0;
    step();

    // ADDI x1,x0,5
    req(4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    req_valid = 1'b0;
    chk("addi_we", {31'd0, we_a}, 32'd1);
    chk("addi_addr", {22'd0, addr_a}, 32'd0);
    chk("addi_word", wdata_a, 32'h00500093);
    chk("addi_lvl", {29'd0, lvl_a}, 32'd1);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("addi_pop_addr", {22'd0, addr_a}, 32'd4);
    chk("addi_pop_we", {31'd0, we_a}, 32'd0);

    // SUB then LUI from a flushed start
    do_flush();
    chk("flush_addr", {22'd0, addr_a}, 32'd0);
    req(4'd0, 5'b10000, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    req(4'd6, 5'b00000, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    step();
    req_valid = 1'b0;
    chk("sub_lvl", {29'd0, lvl_a}, 32'd2);
    chk("sub_word", wdata_a, 32'h402081B3);
    chk("sub_addr", {22'd0, addr_a}, 32'd0);
    imem_ready = 1'b1;
    step();
    chk("lui_word", wdata_a, 32'h123452B7);
    chk("lui_addr", {22'd0, addr_a}, 32'd4);
    step();
    imem_ready = 1'b0;
    chk("lui_pop_lvl", {29'd0, lvl_a}, 32'd0);
    chk("lui_pop_addr", {22'd0, addr_a}, 32'd8);

    // BEQ legal then odd offset
    req(4'd5, 5'd0, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd8);
    step();
    req_valid = 1'b0;
    chk("beq_word", wdata_a, 32'hFE208CE3);
    chk("beq_err", {31'd0, err_a}, 32'd0);
    req(4'd5, 5'd0, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd7);
    step();
    req_valid = 1'b0;
    chk("beq_odd_err", {31'd0, err_a}, 32'd1);
    chk("beq_odd_errc", {24'd0, errc_a}, 32'd1);
    chk("beq_odd_lvl", {29'd0, lvl_a}, 32'd1);
    step();
    chk("err_pulse_end", {31'd0, err_a}, 32'd0);

    // Flush alongside an illegal request: dropped, no error
    req(4'd5, 5'd0, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd7);
    flush = 1'b1;
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("flushreq_err", {31'd0, err_a}, 32'd0);
    chk("flushreq_errc", {24'd0, errc_a}, 32'd1);
    chk("flushreq_lvl", {29'd0, lvl_a}, 32'd0);

    // Burst of 5 ADDIs into a stalled imem
    for (int i = 0; i < 4; i++) begin
      req(4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, i);
      chk($sformatf("burst_ready%0d", i), {31'd0, ready_a}, 32'd1);
      step();
    end
    req(4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4);
    step(); step();
    chk("full_lvl", {29'd0, lvl_a}, 32'd4);
    chk("full_ready", {31'd0, ready_a}, 32'd0);
    chk("full_stable_addr", {22'd0, addr_a}, 32'd0);
    chk("full_stable_word", wdata_a, 32'h00000093);
    imem_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("drain_we%0d", j), {31'd0, we_a}, 32'd1);
      chk($sformatf("drain_word%0d", j), wdata_a, (j << 20) | 32'h93);
      chk($sformatf("drain_addr%0d", j), {22'd0, addr_a}, j * 4);
      chk($sformatf("drain_addr4_%0d", j), {28'd0, addr_b}, (j * 4) % 16);
      step();
      if (j == 0) chk("pop_full_lvl", {29'd0, lvl_a}, 32'd3);
      if (j == 1) begin
        chk("pushpop_lvl", {29'd0, lvl_a}, 32'd3);
        req_valid = 1'b0;
      end
    end
    imem_ready = 1'b0;
    chk("drain_done_we", {31'd0, we_a}, 32'd0);
    chk("drain_done_addr", {22'd0, addr_a}, 32'd20);

    // Flush with three entries queued
    for (int i = 0; i < 3; i++) begin
      req(4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, i);
      step();
    end
    req_valid = 1'b0;
    chk("preflush_lvl", {29'd0, lvl_a}, 32'd3);
    do_flush();
    chk("postflush_lvl", {29'd0, lvl_a}, 32'd0);
    chk("postflush_addr", {22'd0, addr_a}, 32'd0);
    chk("postflush_addr4", {28'd0, addr_b}, 32'd0);

    // SRAI x1,x2,31 ; SW x2,8(x1) ; JAL x1,8
    req(4'd1, 5'b00110, 3'd0, 5'd1, 5'd2, 5'd0, 32'd31);
    step();
    req(4'd4, 5'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
    step();
    req(4'd8, 5'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    step();
    req_valid = 1'b0;
    imem_ready = 1'b1;
    chk("srai_word", wdata_a, 32'h41F15093);
    step();
    chk("sw_word", wdata_a, 32'h0020A423);
    step();
    chk("jal_word", wdata_a, 32'h008000EF);
    step();
    imem_ready = 1'b0;

    // Asynchronous reset in the middle of a burst
    req(4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    step(); step();
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_lvl", {29'd0, lvl_a}, 32'd0);
    chk("areset_we", {31'd0, we_a}, 32'd0);
    chk("areset_errc", {24'd0, errc_a}, 32'd0);
    step();
    reset = 1'b0;

    // ADDI imm=4096 and SRAI imm=32 are illegal
    req(4'd1, 5'b00000, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    step();
    req(4'd1, 5'b00110, 3'd0, 5'd1, 5'd2, 5'd0, 32'd32);
    step();
    req_valid = 1'b0;
    chk("illegal_errc", {24'd0, errc_a}, 32'd2);
    chk("illegal_lvl", {29'd0, lvl_a}, 32'd0);

    // Saturation: class 9 is illegal
    req(4'd9, 5'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < 260; i++) step();
    req_valid = 1'b0;
    chk("sat_errc", {24'd0, errc_a}, 32'd255);
    chk("sat_lvl", {29'd0, lvl_a}, 32'd0);
    step();
    chk("sat_hold", {24'd0, errc_a}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
